// File: rtl/ycell_config_loader.sv
// Serializes host configuration words onto a ycell chain's cbitin/confclk pins,
// holding the fabric in reset until loading starts and capturing the old chain contents.
module ycell_config_loader #(
    parameter int CHAIN_LEN = 48,
    parameter int WORD_W    = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_W   = 1,
    parameter int RST_CYC   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              fab_reset,
    output logic              fab_confclk,
    output logic              fab_cbitin,
    input  logic              fab_cbitout
);
    localparam int BW      = $clog2(CHAIN_LEN + 1);
    localparam int RW      = $clog2(WORD_W + 1);
    localparam int CYC_MAX = (SETUP_CYC > PULSE_W) ?
                             ((SETUP_CYC > RST_CYC) ? SETUP_CYC : RST_CYC) :
                             ((PULSE_W > RST_CYC) ? PULSE_W : RST_CYC);
    localparam int CW      = $clog2(CYC_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_WAIT, S_LOW, S_HIGH, S_DONE} state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cyc_reg, cyc_next;
    logic [BW-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [WORD_W-1:0] word_reg, word_next;
    logic [RW-1:0]     word_left_reg, word_left_next;
    logic [WORD_W-1:0] rb_reg, rb_next;
    logic [RW-1:0]     rb_cnt_reg, rb_cnt_next;
    logic              cbitin_reg, cbitin_next;
    logic              out_valid_reg, out_valid_next;
    logic [WORD_W-1:0] out_data_reg, out_data_next;
    logic              final_bit;
    logic [WORD_W-1:0] rb_ins;

    assign busy        = (state_reg == S_CLEAR) || (state_reg == S_WAIT) ||
                         (state_reg == S_LOW)   || (state_reg == S_HIGH);
    assign done        = (state_reg == S_DONE);
    assign in_ready    = (state_reg == S_WAIT);
    assign fab_reset   = (state_reg == S_IDLE) || (state_reg == S_CLEAR);
    assign fab_confclk = (state_reg == S_HIGH);
    assign fab_cbitin  = cbitin_reg;
    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;

    // The bit currently on cbitin is the last one of the load once CHAIN_LEN-1 strobes are done.
    assign final_bit = (bit_cnt_reg >= BW'(CHAIN_LEN - 1));
    // Captured bits are placed left-aligned so a short final word is already zero-filled.
    assign rb_ins    = rb_reg | (WORD_W'(fab_cbitout) << (RW'(WORD_W - 1) - rb_cnt_reg));

    always_comb begin
        state_next     = state_reg;
        cyc_next       = cyc_reg;
        bit_cnt_next   = bit_cnt_reg;
        word_next      = word_reg;
        word_left_next = word_left_reg;
        rb_next        = rb_reg;
        rb_cnt_next    = rb_cnt_reg;
        cbitin_next    = cbitin_reg;
        out_valid_next = 1'b0;
        out_data_next  = out_data_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next   = S_CLEAR;
                    cyc_next     = '0;
                    bit_cnt_next = '0;
                    rb_next      = '0;
                    rb_cnt_next  = '0;
                end
            end
            S_CLEAR: begin
                if (cyc_reg == CW'(RST_CYC - 1)) begin
                    state_next = S_WAIT;
                    cyc_next   = '0;
                end else begin
                    cyc_next = cyc_reg + CW'(1);
                end
            end
            S_WAIT: begin
                if (in_valid) begin
                    state_next     = S_LOW;
                    cyc_next       = '0;
                    cbitin_next    = in_data[WORD_W-1];
                    word_next      = in_data << 1;
                    word_left_next = RW'(WORD_W - 1);
                end
            end
            S_LOW: begin
                if (cyc_reg == CW'(SETUP_CYC - 1)) begin
                    state_next = S_HIGH;
                    cyc_next   = '0;
                    if (rb_cnt_reg == RW'(WORD_W - 1) || final_bit) begin
                        out_valid_next = 1'b1;
                        out_data_next  = rb_ins;
                        rb_next        = '0;
                        rb_cnt_next    = '0;
                    end else begin
                        rb_next     = rb_ins;
                        rb_cnt_next = rb_cnt_reg + RW'(1);
                    end
                end else begin
                    cyc_next = cyc_reg + CW'(1);
                end
            end
            S_HIGH: begin
                if (cyc_reg == CW'(PULSE_W - 1)) begin
                    cyc_next = '0;
                    if (bit_cnt_reg < BW'(CHAIN_LEN))
                        bit_cnt_next = bit_cnt_reg + BW'(1);
                    if (final_bit) begin
                        state_next = S_DONE;
                    end else if (word_left_reg == '0) begin
                        state_next = S_WAIT;
                    end else begin
                        state_next     = S_LOW;
                        cbitin_next    = word_reg[WORD_W-1];
                        word_next      = word_reg << 1;
                        word_left_next = word_left_reg - RW'(1);
                    end
                end else begin
                    cyc_next = cyc_reg + CW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            cyc_reg       <= '0;
            bit_cnt_reg   <= '0;
            word_reg      <= '0;
            word_left_reg <= '0;
            rb_reg        <= '0;
            rb_cnt_reg    <= '0;
            cbitin_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cyc_reg       <= cyc_next;
            bit_cnt_reg   <= bit_cnt_next;
            word_reg      <= word_next;
            word_left_reg <= word_left_next;
            rb_reg        <= rb_next;
            rb_cnt_reg    <= rb_cnt_next;
            cbitin_reg    <= cbitin_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
        end
    end
endmodule

// File: tb/tb_ycell_config_loader.sv
// Bench for ycell_config_loader: a 9-bit chain model plus strobe-bit and readback scoreboards.
module tb_ycell_config_loader;
    localparam int CHAIN_LEN = 9;
    localparam int WORD_W    = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              busy, done;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WORD_W-1:0] in_data = '0;
    logic              out_valid;
    logic [WORD_W-1:0] out_data;
    logic              fab_reset, fab_confclk, fab_cbitin, fab_cbitout;

    logic [CHAIN_LEN-1:0] chain = '0;
    int                   strobe_count = 0;
    int                   checks = 0;
    int                   errors = 0;
    logic                 exp_bit_q[$];
    logic [WORD_W-1:0]    exp_rb_q[$];

    ycell_config_loader #(
        .CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W), .SETUP_CYC(1), .PULSE_W(1), .RST_CYC(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data),
        .fab_reset(fab_reset), .fab_confclk(fab_confclk),
        .fab_cbitin(fab_cbitin), .fab_cbitout(fab_cbitout)
    );

    always #5 clk = ~clk;

    assign fab_cbitout = chain[CHAIN_LEN-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Chain model and strobe scoreboard: each rising strobe must carry the next expected bit.
    always @(posedge fab_confclk) begin
        chain <= {chain[CHAIN_LEN-2:0], fab_cbitin};
        strobe_count++;
        checks++;
        if (exp_bit_q.size() == 0) begin
            errors++;
            $display("FAIL strobe: unexpected strobe %0d with cbitin=%0b", strobe_count, fab_cbitin);
        end else begin
            logic e;
            e = exp_bit_q.pop_front();
            if (fab_cbitin !== e) begin
                errors++;
                $display("FAIL strobe_bit: strobe %0d got %0b expected %0b", strobe_count, fab_cbitin, e);
            end
        end
    end

    // Readback monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            checks++;
            if (exp_rb_q.size() == 0) begin
                errors++;
                $display("FAIL readback: unexpected out_valid data=%02h", out_data);
            end else begin
                logic [WORD_W-1:0] e;
                e = exp_rb_q.pop_front();
                $display("readback word %02h (expected %02h)", out_data, e);
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL readback_data: got %02h expected %02h", out_data, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bits(input logic [WORD_W-1:0] w, input int n);
        for (int i = 0; i < n; i++) exp_bit_q.push_back(w[WORD_W-1-i]);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("in_ready_timeout", in_ready, 1'b1);
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w);
        wait_ready();
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        $display("sent word %02h", w);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        check("done_timeout", done, 1'b1);
        check("busy_at_done", busy, 1'b0);
        check("fab_reset_at_done", fab_reset, 1'b0);
    endtask

    task automatic gap_wait(input int cycles);
        wait_ready();
        for (int i = 0; i < cycles; i++) begin
            tick();
            check("gap_confclk", fab_confclk, 1'b0);
            check("gap_in_ready", in_ready, 1'b1);
        end
    endtask

    initial begin
        int base;
        // Reset values
        repeat (3) tick();
        check("rst_fab_reset", fab_reset, 1'b1);
        check("rst_confclk", fab_confclk, 1'b0);
        check("rst_cbitin", fab_cbitin, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        reset = 1'b0;
        tick();
        check("idle_fab_reset", fab_reset, 1'b1);

        // Basic load, with CLEAR timing checks
        push_bits(8'hA5, 8); push_bits(8'h80, 1);
        exp_rb_q.push_back(8'h00); exp_rb_q.push_back(8'h00);
        pulse_start();
        check("clear1_busy", busy, 1'b1);
        check("clear1_fab_reset", fab_reset, 1'b1);
        check("clear1_in_ready", in_ready, 1'b0);
        tick();
        check("clear2_in_ready", in_ready, 1'b0);
        tick();
        check("wait_in_ready", in_ready, 1'b1);
        check("wait_fab_reset", fab_reset, 1'b0);
        send_word(8'hA5);
        check("first_bit_cbitin", fab_cbitin, 1'b1);
        check("first_low_confclk", fab_confclk, 1'b0);
        tick();
        check("first_high_confclk", fab_confclk, 1'b1);
        send_word(8'h80);
        wait_done();
        check("chain_basic", chain, 9'b101001011);

        // Readback of the previous load, with a 10-cycle host gap between words
        push_bits(8'h3C, 8); push_bits(8'h00, 1);
        exp_rb_q.push_back(8'hA5); exp_rb_q.push_back(8'h80);
        pulse_start();
        send_word(8'h3C);
        gap_wait(10);
        send_word(8'h00);
        wait_done();
        check("chain_readback", chain, 9'b001111000);

        // Reset after the 4th strobe truncates the load
        push_bits(8'h96, 4);
        pulse_start();
        base = strobe_count;
        send_word(8'h96);
        for (int n = 0; n < 50 && strobe_count < base + 4; n++) tick();
        check("mid_strobe_count", strobe_count, base + 4);
        reset = 1'b1;
        tick();
        check("mid_rst_fab_reset", fab_reset, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_confclk", fab_confclk, 1'b0);
        reset = 1'b0;
        repeat (20) tick();
        check("mid_no_more_strobes", strobe_count, base + 4);
        check("chain_truncated", chain, 9'b110001001);

        // Reload, with start pulsed during LOW/HIGH
        push_bits(8'hA5, 8); push_bits(8'h80, 1);
        exp_rb_q.push_back(8'hC4); exp_rb_q.push_back(8'h80);
        pulse_start();
        send_word(8'hA5);
        pulse_start();
        check("ignored_start_busy", busy, 1'b1);
        send_word(8'h80);
        wait_done();
        check("chain_reload", chain, 9'b101001011);

        // start in DONE restarts immediately
        push_bits(8'h00, 8); push_bits(8'h00, 1);
        exp_rb_q.push_back(8'hA5); exp_rb_q.push_back(8'h80);
        tick();
        pulse_start();
        check("restart_done", done, 1'b0);
        check("restart_busy", busy, 1'b1);
        check("restart_fab_reset", fab_reset, 1'b1);
        send_word(8'h00);
        send_word(8'h00);
        wait_done();
        check("chain_zero", chain, 9'b000000000);

        repeat (3) tick();
        check("bits_left", exp_bit_q.size(), 0);
        check("readbacks_left", exp_rb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
